// File: rtl/key_event_ctrl_pkg.sv
// rtl/key_event_ctrl_pkg.sv - shared types, widths and helpers for the keypad event sequencer
package key_event_ctrl_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int ROW_W      = 2;
    localparam int COL_N      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

    // Index of the lowest set bit; returns 0 for an empty mask (caller never asks then).
    function automatic logic [1:0] lowest_set_idx(input logic [COL_N-1:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = COL_N - 1; i >= 0; i--) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// rtl/key_evt_fifo.sv - registered sync FIFO holding key events, no fall-through
module key_evt_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 4,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             push_drop
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        empty     = (level_q == '0);
        full      = (level_q == LVL_W'(DEPTH));
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        push_drop = push && !do_push;
        level_d   = level_q;
        if (do_push && !do_pop) level_d = level_q + LVL_W'(1);
        if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
    end

    // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - turns scanner row results into a queue of key-press events
module key_event_ctrl
    import key_event_ctrl_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CAP_DLY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         row_rdy,
    input  logic [ROW_W-1:0]             row_idx,
    input  logic [COL_N-1:0]             col_n,
    output logic                         key_valid,
    output logic [KEY_CODE_W-1:0]        key_code,
    input  logic                         key_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         key_irq,
    output logic                         ovf,
    input  logic                         ovf_clr
);

    localparam int DLY_W    = (CAP_DLY > 1) ? $clog2(CAP_DLY) : 1;
    localparam int DLY_INIT = (CAP_DLY > 0) ? CAP_DLY - 1 : 0;

    state_e           state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [COL_N-1:0] pend_q, pend_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             ovf_q, ovf_d;
    logic             push, lost_row, push_drop, fifo_full, fifo_empty;
    logic [1:0]       scan_col;

    assign scan_col = lowest_set_idx(pend_q);

    // Next-state: settle delay, mask capture, one key code per cycle while scanning.
    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        pend_d   = pend_q;
        row_d    = row_q;
        push     = 1'b0;
        lost_row = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (row_rdy) begin
                    if (CAP_DLY == 0) begin
                        pend_d  = ~col_n;
                        row_d   = row_idx;
                        state_d = (col_n != '1) ? ST_SCAN : ST_IDLE;
                    end else begin
                        dly_d   = DLY_W'(DLY_INIT);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                lost_row = row_rdy;
                if (dly_q == '0) begin
                    pend_d  = ~col_n;
                    row_d   = row_idx;
                    state_d = (col_n != '1) ? ST_SCAN : ST_IDLE;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_SCAN: begin
                lost_row = row_rdy;
                push     = 1'b1;
                pend_d   = pend_q & ~(COL_N'(1) << scan_col);
                if (pend_d == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new loss outranks a clear arriving in the same cycle.
        if (lost_row || push_drop) ovf_d = 1'b1;
        else if (ovf_clr)          ovf_d = 1'b0;
        else                       ovf_d = ovf_q;
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            pend_q  <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            pend_q  <= pend_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
        end
    end

    key_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (KEY_CODE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wdata     ({row_q, scan_col}),
        .pop       (key_ready),
        .rdata     (key_code),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (push_drop)
    );

    assign key_valid = !fifo_empty;
    assign key_irq   = !fifo_empty;
    assign ovf       = ovf_q;

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Sequences the 4x4 keypad scanner's per-row results into discrete key-press events.
- On each scanner row-ready pulse it captures the row index and the active-low new-press column mask.
- It serialises the set bits, one key code per clock, into a small FIFO.
- The FIFO presents events to the SoC bus/buzzer sequencer over a valid/ready handshake, with a level output, an interrupt and a sticky overflow flag.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- CAP_DLY, 2: clk cycles from the row_rdy pulse to sampling row_idx/col_n, to let the scanner's row outputs settle.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- row_rdy  in  1  one-clk pulse from the scanner when a new row result is produced
- row_idx  in  2  scanner row index for that result
- col_n  in  4  active-low new-press mask (bit i = 0 means column i newly pressed)
- key_valid  out  1  FIFO head holds an event
- key_code  out  4  head event {row_idx, col[1:0]}
- key_ready  in  1  consumer accepts the head when key_valid && key_ready
- fifo_level  out  $clog2(DEPTH+1)  number of stored events
- key_irq  out  1  level interrupt, equals key_valid
- ovf  out  1  sticky: an event or row result was lost
- ovf_clr  in  1  one-clk clear of ovf

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. All state is on posedge clk.
- Reset values: state IDLE, FIFO empty, key_valid=0, key_code=0, fifo_level=0, key_irq=0, ovf=0. Asserting rst mid-scan discards the pending mask and all FIFO contents.
- FSM states: IDLE, WAIT, SCAN.
- IDLE:
  - row_rdy=1: load dly_cnt=CAP_DLY-1, go to WAIT.
  - If CAP_DLY=0: capture on the same edge and go directly to SCAN (or stay in IDLE if the mask is zero).
- WAIT:
  - Decrement dly_cnt.
  - At dly_cnt==0: capture pend=~col_n and row_q=row_idx.
  - Then go to SCAN if pend!=0, else IDLE.
- SCAN:
  - Each cycle, select the lowest set bit c of pend.
  - Push {row_q, c}, clear bit c.
  - When the pend value after clearing is 0, go to IDLE.
  - Latency: a key in column c is pushed CAP_DLY+1+(number of set bits below c) cycles after row_rdy. It is visible on key_valid the cycle after the push.
- row_rdy while in WAIT or SCAN: ignored; set ovf.
- FIFO:
  - Registered pointers and head output; no fall-through.
  - key_code = mem[rd_ptr]; key_valid = (level != 0).
  - Pop when key_valid && key_ready.
  - Push accepted if level < DEPTH, or if a pop occurs in the same cycle (full + pop + push: level unchanged).
  - Push with full and no pop: event dropped, ovf set; the scan continues regardless.
  - Pointers wrap modulo DEPTH. level = pushes − pops, saturating is not required because it is bounded by the rules above.
  - key_ready while empty: no effect.
- ovf:
  - Set on any loss event.
  - ovf_clr clears it.
  - A loss and ovf_clr in the same cycle: set wins.

Decomposition:
- Shared package contents:
  - FSM state encoding (ST_IDLE, ST_WAIT, ST_SCAN).
  - KEY_CODE_W=4, ROW_W=2, COL_N=4.
  - Function lowest_set_idx(4-bit) returning 2 bits.
- Natural sub-module: key_evt_fifo, a parameterised sync FIFO with push/pop/level/full.
- The FSM, capture and ovf logic stay in key_event_ctrl.

Test Plan:
- Single key, CAP_DLY=2, row_idx=2, col_n=4'b1011, row_rdy pulse at T:
  - Push at T+3, key_valid=1 at T+4, key_code=4'b1010.
  - Pop with key_ready → key_valid=0, fifo_level=0.
- Multi-key row, row_idx=1, col_n=4'b0100:
  - Codes 4'h4, 4'h5, 4'h7 pushed on consecutive cycles.
  - fifo_level reaches 3 and key_irq=1.
- Zero mask, col_n=4'hF: FSM returns to IDLE after WAIT, nothing pushed, ovf stays 0.
- Overflow, DEPTH=8, key_ready=0:
  - Three rows of 4 presses (12 events) → first 8 stored, ovf=1.
  - Drain yields 8 codes in order.
  - ovf_clr → ovf=0.
- Full + simultaneous pop:
  - Fill to 8, then a 1-key row with key_ready held high during its push cycle.
  - fifo_level stays 8, ovf=0, order preserved.
- row_rdy during SCAN sets ovf without disturbing the scan in progress.
- rst asserted mid-SCAN with fifo_level=3:
  - All outputs are at reset values immediately (async).
  - After release, a new row_rdy works normally.
